modulo_conversor_bin_bcd_7_bits: RTL
====================================

Name: modulo_conversor_bin_bcd_7_bits

Overview:
Sequential binary-to-BCD converter (shift-and-add-3) for the 7-bit count value produced by the synchronous up-counter stage. It is the downstream consumer of the counter: it samples the 7-bit count on request and produces hundreds/tens/units BCD digits for the display stage. It has a start/busy/done handshake, runs one shift per clock, and holds the last result until the next conversion completes.

Parameters:
LARGURA, 7, width of the binary input (the block is specified and verified only at 7).
ITERACOES, 7, number of shift iterations; equals LARGURA.

Ports:
clk  input  1  single system clock; rising-edge active.
clr  input  1  asynchronous, active-high reset; clears all state and outputs.
iniciar  input  1  start request; sampled on clk rising edge, honoured only when idle.
bin_in  input  7  binary value to convert (counter q output); sampled only on an accepted start edge.
ocupado  output  1  high while a conversion is in progress.
pronto  output  1  one-cycle pulse when new digits are valid.
centena  output  4  BCD hundreds digit (0..1 for 7-bit input; bits [3:1] always 0).
dezena  output  4  BCD tens digit.
unidade  output  4  BCD units digit.

Behaviour:
- Reset (clr=1, asynchronous): state=OCIOSO; shift register, iteration counter, centena, dezena and unidade = 0; ocupado=0; pronto=0. Reset takes effect immediately regardless of clk, and also aborts any conversion in progress; the partial result is discarded.
- States: OCIOSO, CONVERTE.
- OCIOSO: on an edge with iniciar=1, load the internal register with {12'b0, bin_in}, set the iteration counter to 0, go to CONVERTE, and set ocupado=1 from the next cycle. With iniciar=0, stay in OCIOSO.
- CONVERTE: on each edge, run one iteration:
  - every BCD nibble whose value is >=5 gets +3 (the three nibbles are corrected in parallel, combinationally);
  - then the whole 19-bit register shifts left by 1;
  - the counter increments.
- When the 7th iteration completes, the corrected, shifted nibbles are written into centena/dezena/unidade on that same edge. On that edge: pronto=1 for exactly one cycle, ocupado=0, state goes to OCIOSO.
- Latency: start accepted at edge k, results visible and pronto high after edge k+7. A conversion is 7 cycles of ocupado.
- iniciar while ocupado=1 is ignored. It is not queued and does not restart the conversion.
- iniciar=1 during the pronto cycle is accepted, because the state is already OCIOSO. Back-to-back throughput is one conversion per 8 cycles.
- Changes to bin_in after the start edge have no effect on the running conversion.
- Outputs hold the previous result through a conversion and change only on the completion edge.
- Arithmetic: nibble correction is 4-bit with no carry-out; correction happens only on values 5..9, so the result never exceeds 12 before the shift.
- Input range is 0..127; all values are legal.

Decomposition:
- Shared package holds:
  - LARGURA = 7 and ITERACOES = 7;
  - the state encoding (OCIOSO = 1'b0, CONVERTE = 1'b1);
  - the BCD correction threshold (5) and offset (3).
- One sub-module: modulo_ajuste_bcd, a combinational 4-bit "if >=5 add 3" cell, instantiated three times (hundreds, tens, units).
- The iteration counter is a 3-bit register inside the top block.

Test Plan:
1. Reset, then bin_in=127 with a 1-cycle iniciar → ocupado high 7 cycles; pronto pulses once after edge k+7 with centena=1, dezena=2, unidade=7.
2. bin_in=0, then 99, then 100, each run to completion → (0,0,0), (0,9,9), (1,0,0); ocupado=0 and pronto=0 between runs.
3. Start with bin_in=45, assert iniciar again at cycle k+3 with bin_in=10 → only one pronto, at k+7, with (0,4,5); no second conversion.
4. Start with bin_in=64, change bin_in to 3 at k+1 → result (0,6,4).
5. Start with bin_in=88, assert clr asynchronously mid-cycle at k+4 → all outputs 0 immediately, state OCIOSO, no pronto. After release, start with bin_in=5 → (0,0,5).
6. Back-to-back: iniciar held high continuously with bin_in stepping 0..127 like the counter → each pronto, every 8 cycles, carries the BCD of the value sampled at the corresponding start edge; exhaustive compare against a reference model.

Source files
------------

// File: rtl/modulo_conversor_bin_bcd_7_bits_pkg.sv
// Shared constants for the 7-bit binary-to-BCD converter: widths, FSM encoding
// and the shift-and-add-3 correction constants.
package modulo_conversor_bin_bcd_7_bits_pkg;

  localparam int LARGURA   = 7;
  localparam int ITERACOES = 7;
  localparam int LARG_BCD  = 12;

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

  localparam logic [3:0] LIMIAR_BCD = 4'd5;
  localparam logic [3:0] AJUSTE_BCD = 4'd3;

endpackage

// File: rtl/modulo_conversor_bin_bcd_7_bits_ajuste_bcd.sv
// Combinational "if >= 5 add 3" correction cell for one BCD nibble.
module modulo_ajuste_bcd
  import modulo_conversor_bin_bcd_7_bits_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] ajustado
);

  // Correct nibble before the shift; inputs 5..9 never exceed 12, so 4 bits suffice
  always_comb begin
    ajustado = nibble;
    if (nibble >= LIMIAR_BCD) begin
      ajustado = nibble + AJUSTE_BCD;
    end else begin
      ajustado = nibble;
    end
  end

endmodule

// File: rtl/modulo_conversor_bin_bcd_7_bits.sv
// Sequential shift-and-add-3 converter: samples a 7-bit count on iniciar and
// delivers hundreds/tens/units after 7 cycles, holding the result until the next one.
module modulo_conversor_bin_bcd_7_bits
  import modulo_conversor_bin_bcd_7_bits_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] bin_in,
  output logic               ocupado,
  output logic               pronto,
  output logic [3:0]         centena,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade
);

  localparam int LARG_REG = LARG_BCD + LARGURA;

  estado_t             estado_r;
  logic [LARG_REG-1:0] desloc_r;
  logic [2:0]          iter_r;
  logic [3:0]          cen_aj_s;
  logic [3:0]          dez_aj_s;
  logic [3:0]          uni_aj_s;
  logic [LARG_REG-1:0] corrigido_s;
  logic [LARG_REG-1:0] proximo_s;

  modulo_ajuste_bcd u_ajuste_centena (.nibble(desloc_r[LARG_REG-1 -: 4]),     .ajustado(cen_aj_s));
  modulo_ajuste_bcd u_ajuste_dezena  (.nibble(desloc_r[LARGURA+7 -: 4]),      .ajustado(dez_aj_s));
  modulo_ajuste_bcd u_ajuste_unidade (.nibble(desloc_r[LARGURA+3 -: 4]),      .ajustado(uni_aj_s));

  assign corrigido_s = {cen_aj_s, dez_aj_s, uni_aj_s, desloc_r[LARGURA-1:0]};
  assign proximo_s   = {corrigido_s[LARG_REG-2:0], 1'b0};

  // Conversion FSM: one correct-then-shift iteration per clock, outputs updated on the last
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      estado_r <= OCIOSO;
      desloc_r <= '0;
      iter_r   <= 3'd0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      centena  <= 4'd0;
      dezena   <= 4'd0;
      unidade  <= 4'd0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          pronto <= 1'b0;
          if (iniciar) begin
            desloc_r <= {{LARG_BCD{1'b0}}, bin_in};
            iter_r   <= 3'd0;
            ocupado  <= 1'b1;
            estado_r <= CONVERTE;
          end else begin
            ocupado  <= 1'b0;
            estado_r <= OCIOSO;
          end
        end
        CONVERTE: begin
          desloc_r <= proximo_s;
          iter_r   <= iter_r + 3'd1;
          if (iter_r == 3'(ITERACOES - 1)) begin
            centena  <= proximo_s[LARG_REG-1 -: 4];
            dezena   <= proximo_s[LARGURA+7 -: 4];
            unidade  <= proximo_s[LARGURA+3 -: 4];
            pronto   <= 1'b1;
            ocupado  <= 1'b0;
            estado_r <= OCIOSO;
          end else begin
            pronto   <= 1'b0;
            ocupado  <= 1'b1;
            estado_r <= CONVERTE;
          end
        end
        default: begin
          estado_r <= OCIOSO;
          ocupado  <= 1'b0;
          pronto   <= 1'b0;
        end
      endcase
    end
  end

endmodule
